// File: rtl/keypad_emulator_if.sv
// Request channel into the keypad emulator: a 4-bit key code with valid/ready flow control.
// A code transfers on a rising CLK edge where key_valid && key_ready are both high.
interface keypad_emulator_if;
  logic [3:0] key_in;
  logic       key_valid;
  logic       key_ready;

  modport master (output key_in, output key_valid, input key_ready);
  modport slave  (input key_in, input key_valid, output key_ready);
endinterface

// File: rtl/keypad_emulator.sv
// Emulates a 4x4 matrix keypad: queued key codes are "pressed" one at a time,
// returning the scanner's column drive on the key's row for HOLD_CYCLES, then releasing for GAP_CYCLES.
module keypad_emulator #(
  parameter int unsigned HOLD_CYCLES = 64,
  parameter int unsigned GAP_CYCLES  = 32
) (
  input  logic              CLK,
  input  logic              RST,
  keypad_emulator_if.slave  kif,
  input  logic [3:0]        C,
  output logic [3:0]        R,
  output logic [4:0]        active_key,
  output logic              busy,
  output logic [2:0]        fifo_level,
  output logic [1:0]        o_state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] GAP_LOAD  = 16'(GAP_CYCLES - 1);
  localparam logic [4:0]  NO_KEY    = 5'b10000;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_nxt;

  logic [3:0]  r_mem [4];
  logic [1:0]  r_wr_ptr;
  logic [1:0]  r_rd_ptr;
  logic [2:0]  r_level;
  logic        w_push;
  logic        w_pop;
  logic        w_empty;
  logic        w_full;
  logic [3:0]  w_head;

  logic [3:0]  r_code;
  logic [1:0]  r_col;
  logic [1:0]  r_row;
  logic [4:0]  r_active_key;
  logic [3:0]  w_pos;
  logic [3:0]  w_r;

  // Matrix location of a code, returned as {column, row}.
  function automatic logic [3:0] code_to_pos(input logic [3:0] code);
    logic [3:0] pos;
    case (code)
      4'h0: pos = {2'd3, 2'd0};
      4'h1: pos = {2'd0, 2'd3};
      4'h2: pos = {2'd3, 2'd3};
      4'h3: pos = {2'd2, 2'd3};
      4'h4: pos = {2'd0, 2'd2};
      4'h5: pos = {2'd3, 2'd2};
      4'h6: pos = {2'd2, 2'd2};
      4'h7: pos = {2'd0, 2'd1};
      4'h8: pos = {2'd3, 2'd1};
      4'h9: pos = {2'd2, 2'd1};
      4'hA: pos = {2'd1, 2'd3};
      4'hB: pos = {2'd1, 2'd2};
      4'hC: pos = {2'd1, 2'd1};
      4'hD: pos = {2'd1, 2'd0};
      4'hE: pos = {2'd0, 2'd0};
      default: pos = {2'd2, 2'd0};
    endcase
    return pos;
  endfunction

  assign w_empty = (r_level == 3'd0);
  assign w_full  = (r_level == 3'd4);
  assign w_push  = kif.key_valid && !w_full;
  assign w_head  = r_mem[r_rd_ptr];
  assign w_pos   = code_to_pos(w_head);

  // Storage is not reset; only pointers and level define which entries are live.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= kif.key_in;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_level  <= 3'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 3'd1;
        2'b01:   r_level <= r_level - 3'd1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_cnt   <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_cnt_nxt   = HOLD_LOAD;
          w_state_nxt = ST_PRESS;
        end
      end
      ST_PRESS: begin
        if (r_cnt == 16'd0) begin
          w_cnt_nxt   = GAP_LOAD;
          w_state_nxt = ST_GAP;
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      ST_GAP: begin
        if (r_cnt == 16'd0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 16'd0;
      end
    endcase
  end

  // active_key is computed from the next state so it lines up exactly with the PRESS window.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_code       <= 4'd0;
      r_col        <= 2'd0;
      r_row        <= 2'd0;
      r_active_key <= NO_KEY;
    end else begin
      if (w_pop) begin
        r_code <= w_head;
        r_col  <= w_pos[3:2];
        r_row  <= w_pos[1:0];
      end
      if (w_state_nxt == ST_PRESS) begin
        r_active_key <= {1'b0, (w_pop ? w_head : r_code)};
      end else begin
        r_active_key <= NO_KEY;
      end
    end
  end

  // The pressed switch connects one column to one row, so several low columns behave naturally.
  always_comb begin
    w_r = 4'b1111;
    if (r_state == ST_PRESS) begin
      w_r[r_row] = C[r_col];
    end
  end

  assign R             = w_r;
  assign active_key    = r_active_key;
  assign busy          = !w_empty || (r_state != ST_IDLE);
  assign fifo_level    = r_level;
  assign kif.key_ready = !w_full;
  assign o_state_dbg   = r_state;

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator with HOLD_CYCLES=4, GAP_CYCLES=2.
// Outputs are sampled 1 time unit after each rising edge; inputs are driven there too.
module tb_keypad_emulator;

  logic       CLK;
  logic       RST;
  logic [3:0] C;
  logic [3:0] R;
  logic [4:0] active_key;
  logic       busy;
  logic [2:0] fifo_level;
  logic [1:0] state_dbg;

  keypad_emulator_if kif ();

  keypad_emulator #(
    .HOLD_CYCLES (4),
    .GAP_CYCLES  (2)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .kif         (kif),
    .C           (C),
    .R           (R),
    .active_key  (active_key),
    .busy        (busy),
    .fifo_level  (fifo_level),
    .o_state_dbg (state_dbg)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp;
  int n_fail;
  logic [3:0] exp_q[$];
  logic [3:0] obs_q[$];

  // Hand-derived matrix location of each code 0..F.
  int exp_col [16] = '{3, 0, 3, 2, 0, 3, 2, 0, 3, 2, 1, 1, 1, 1, 0, 2};
  int exp_row [16] = '{0, 3, 3, 3, 2, 2, 2, 1, 1, 1, 3, 2, 1, 0, 0, 0};

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 60; i++) begin
      if (!busy) break;
      step();
    end
    check(tag, 16'(busy), 16'd0);
  endtask

  task automatic collect_presses(input string tag);
    logic prev_rel;
    prev_rel = 1'b1;
    obs_q.delete();
    for (int i = 0; i < 200; i++) begin
      if (prev_rel && !active_key[4]) obs_q.push_back(active_key[3:0]);
      prev_rel = active_key[4];
      if (!busy) break;
      step();
    end
    check({tag, "_timeout"}, 16'(busy), 16'd0);
  endtask

  task automatic compare_order(input string tag);
    check({tag, "_count"}, 16'(obs_q.size()), 16'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check($sformatf("%s_key%0d", tag, i), 16'(obs_q[i]), 16'(exp_q[i]));
    end
  endtask

  task automatic push_one(input logic [3:0] code);
    kif.key_in    = code;
    kif.key_valid = 1'b1;
    step();
    kif.key_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] e_r;
    n_cmp = 0;
    n_fail = 0;
    RST = 1'b1;
    C = 4'hF;
    kif.key_in = 4'h0;
    kif.key_valid = 1'b0;
    #1;
    check("rst_level", 16'(fifo_level), 16'd0);
    check("rst_active", 16'(active_key), 16'h10);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_ready", 16'(kif.key_ready), 16'd1);
    check("rst_r", 16'(R), 16'hF);
    check("rst_state", 16'(state_dbg), 16'd0);
    step();
    step();
    #3 RST = 1'b0;
    step();

    // Single press of 5 with column 3 driven low.
    C = 4'b0111;
    push_one(4'h5);
    check("t1_level", 16'(fifo_level), 16'd1);
    check("t1_busy", 16'(busy), 16'd1);
    step();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t1_r_c%0d", i), 16'(R), 16'hB);
      check($sformatf("t1_act_c%0d", i), 16'(active_key), 16'h05);
      step();
    end
    check("t1_r_gap", 16'(R), 16'hF);
    check("t1_act_gap", 16'(active_key), 16'h10);
    check("t1_busy_gap0", 16'(busy), 16'd1);
    step();
    check("t1_busy_gap1", 16'(busy), 16'd1);
    step();
    check("t1_busy_end", 16'(busy), 16'd0);

    // Column sweep while 7 is held.
    C = 4'hF;
    push_one(4'h7);
    step();
    C = 4'b1110; #1 check("t2_c1110", 16'(R), 16'hD);
    C = 4'b1101; #1 check("t2_c1101", 16'(R), 16'hF);
    C = 4'b1011; #1 check("t2_c1011", 16'(R), 16'hF);
    C = 4'b0111; #1 check("t2_c0111", 16'(R), 16'hF);
    C = 4'hF;
    wait_idle("t2_idle");

    // Fill the FIFO with A..D during a press of 0, then offer E while full.
    kif.key_in = 4'h0;
    kif.key_valid = 1'b1;
    step();
    kif.key_in = 4'hA; step();
    check("t3_pushpop_level", 16'(fifo_level), 16'd1);
    kif.key_in = 4'hB; step();
    kif.key_in = 4'hC; step();
    kif.key_in = 4'hD; step();
    check("t3_full_level", 16'(fifo_level), 16'd4);
    check("t3_full_ready", 16'(kif.key_ready), 16'd0);
    kif.key_in = 4'hE; step();
    check("t3_hold_e_level0", 16'(fifo_level), 16'd4);
    check("t3_hold_e_ready0", 16'(kif.key_ready), 16'd0);
    step();
    check("t3_hold_e_level1", 16'(fifo_level), 16'd4);
    check("t3_hold_e_ready1", 16'(kif.key_ready), 16'd0);
    kif.key_valid = 1'b0;
    collect_presses("t3");
    exp_q = '{4'hA, 4'hB, 4'hC, 4'hD};
    compare_order("t3");

    // Push while popping with two entries queued in IDLE.
    kif.key_in = 4'h1;
    kif.key_valid = 1'b1;
    step();
    kif.key_in = 4'h2; step();
    kif.key_in = 4'h3; step();
    kif.key_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (state_dbg == 2'd0) break;
      step();
    end
    check("t4_idle_state", 16'(state_dbg), 16'd0);
    check("t4_idle_level", 16'(fifo_level), 16'd2);
    push_one(4'h4);
    check("t4_pushpop_level", 16'(fifo_level), 16'd2);
    collect_presses("t4");
    exp_q = '{4'h2, 4'h3, 4'h4};
    compare_order("t4");

    // Reset in the middle of a press of F with a code still queued.
    C = 4'b1011;
    push_one(4'hF);
    kif.key_in = 4'h9;
    kif.key_valid = 1'b1;
    step();
    kif.key_valid = 1'b0;
    check("t5_r_press", 16'(R), 16'hE);
    check("t5_level_pre", 16'(fifo_level), 16'd1);
    #2 RST = 1'b1;
    #1;
    check("t5_r_rst", 16'(R), 16'hF);
    check("t5_level_rst", 16'(fifo_level), 16'd0);
    check("t5_act_rst", 16'(active_key), 16'h10);
    check("t5_busy_rst", 16'(busy), 16'd0);
    check("t5_ready_rst", 16'(kif.key_ready), 16'd1);
    check("t5_state_rst", 16'(state_dbg), 16'd0);
    #2 RST = 1'b0;
    C = 4'hF;
    push_one(4'h2);
    check("t5_first_push", 16'(fifo_level), 16'd1);
    step();
    check("t5_first_press", 16'(active_key), 16'h02);
    wait_idle("t5_idle");

    // Every code against every single column, plus all columns low at once.
    for (int k = 0; k < 16; k++) begin
      push_one(4'(k));
      step();
      check($sformatf("map_act_%0h", k), 16'(active_key), 16'(k));
      for (int c = 0; c < 4; c++) begin
        C = 4'hF;
        C[c] = 1'b0;
        #1;
        e_r = 4'hF;
        if (c == exp_col[k]) e_r[exp_row[k]] = 1'b0;
        check($sformatf("map_%0h_col%0d", k, c), 16'(R), 16'(e_r));
      end
      C = 4'h0;
      #1;
      e_r = 4'hF;
      e_r[exp_row[k]] = 1'b0;
      check($sformatf("map_%0h_allcols", k), 16'(R), 16'(e_r));
      C = 4'hF;
      wait_idle($sformatf("map_%0h_idle", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
